// File: rtl/l1a_match_gen_if.sv
//------------------------------------------------------------------------------
// Module      : l1a_match_gen_if
// Description : LCT/L1A inputs, configuration and match/status outputs of
//               l1a_match_gen.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface l1a_match_gen_if #(
    parameter int DEPTH = 16
);
    localparam int c_pw = $clog2(DEPTH) + 1;

    logic            LCT;
    logic            L1A;
    logic            LAT_12_5US;
    logic            MTCH_3BX;
    logic [5:0]      LCT_L1A_DLY;
    logic            L1A_OUT;
    logic            L1A_MATCH;
    logic            LCT_TIMEOUT;
    logic [c_pw-1:0] PENDING;
    logic            FULL;
    logic            OVF;

    modport master (
        output LCT, L1A, LAT_12_5US, MTCH_3BX, LCT_L1A_DLY,
        input  L1A_OUT, L1A_MATCH, LCT_TIMEOUT, PENDING, FULL, OVF
    );

    modport slave (
        input  LCT, L1A, LAT_12_5US, MTCH_3BX, LCT_L1A_DLY,
        output L1A_OUT, L1A_MATCH, LCT_TIMEOUT, PENDING, FULL, OVF
    );
endinterface

`default_nettype wire

// File: rtl/l1a_match_gen.sv
//------------------------------------------------------------------------------
// Module      : l1a_match_gen
// Description : Timestamps LCTs into a due-time FIFO and qualifies each L1A
//               against the oldest pending LCT, producing L1A_OUT/L1A_MATCH.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module l1a_match_gen #(
    parameter int DEPTH = 16,
    parameter int TMR   = 0
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    l1a_match_gen_if.slave  bus
);
    localparam int c_aw     = $clog2(DEPTH);
    localparam int c_cw     = c_aw + 1;
    localparam int c_sw     = 12 + 2 * c_aw + c_cw;
    localparam int c_copies = (TMR != 0) ? 3 : 1;
    localparam logic [c_cw-1:0] c_full_cnt = c_cw'(DEPTH);

    logic [c_sw-1:0]   w_st;
    logic [c_sw-1:0]   w_st_next;
    logic [11:0]       w_bx;
    logic [c_aw-1:0]   w_wr_ptr;
    logic [c_aw-1:0]   w_rd_ptr;
    logic [c_cw-1:0]   w_count;
    logic [c_cw-1:0]   w_count_next;
    logic [11:0]       w_lat;
    logic [11:0]       w_due;
    logic [11:0]       w_head;
    logic [11:0]       w_diff;
    logic signed [11:0] w_win;
    logic              w_empty;
    logic              w_full;
    logic              w_in_win;
    logic              w_expired;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    logic [11:0]       r_mem [DEPTH];
    logic              r_l1a_out;
    logic              r_l1a_match;
    logic              r_timeout;
    logic              r_ovf;

    // BX counter, both pointers and the occupancy count share one state word so
    // the triplicated build votes them together.
    assign {w_bx, w_wr_ptr, w_rd_ptr, w_count} = w_st;

    genvar gi;
    for (gi = 0; gi < c_copies; gi++) begin : g_copy
        logic [c_sw-1:0] r_st;
        always_ff @(posedge CLK) begin
            if (RST) r_st <= '0;
            else     r_st <= w_st_next;
        end
    end

    if (TMR != 0) begin : g_vote
        assign w_st = (g_copy[0].r_st & g_copy[1].r_st) |
                      (g_copy[0].r_st & g_copy[2].r_st) |
                      (g_copy[1].r_st & g_copy[2].r_st);
    end else begin : g_single
        assign w_st = g_copy[0].r_st;
    end

    assign w_lat   = (bus.LAT_12_5US ? 12'd500 : 12'd128) + {6'd0, bus.LCT_L1A_DLY};
    assign w_due   = w_bx + w_lat;
    assign w_head  = r_mem[w_rd_ptr];
    assign w_diff  = w_bx - w_head;
    assign w_win   = bus.MTCH_3BX ? 12'sd1 : 12'sd2;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == c_full_cnt);

    // Latency never exceeds 563 BX, so the 12-bit signed difference stays
    // unambiguous across the counter wrap.
    assign w_in_win  = !w_empty && ($signed(w_diff) >= -w_win) && ($signed(w_diff) <= w_win);
    assign w_expired = !w_empty && ($signed(w_diff) > w_win);

    // An L1A landing on an expired head blocks the pop; the timeout follows next cycle.
    assign w_pop  = bus.L1A ? w_in_win : w_expired;
    assign w_push = bus.LCT && (!w_full || w_pop);
    assign w_drop = bus.LCT && w_full && !w_pop;

    assign w_count_next = w_count + c_cw'(w_push) - c_cw'(w_pop);
    assign w_st_next    = {w_bx + 12'd1,
                           w_push ? w_wr_ptr + c_aw'(1) : w_wr_ptr,
                           w_pop  ? w_rd_ptr + c_aw'(1) : w_rd_ptr,
                           w_count_next};

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[w_wr_ptr] <= w_due;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_l1a_out   <= 1'b0;
            r_l1a_match <= 1'b0;
            r_timeout   <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_l1a_out   <= bus.L1A;
            r_l1a_match <= bus.L1A && w_in_win;
            r_timeout   <= !bus.L1A && w_expired;
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign bus.L1A_OUT     = r_l1a_out;
    assign bus.L1A_MATCH   = r_l1a_match;
    assign bus.LCT_TIMEOUT = r_timeout;
    assign bus.PENDING     = w_count;
    assign bus.FULL        = w_full;
    assign bus.OVF         = r_ovf;
endmodule

`default_nettype wire
